// File: rtl/ts_ser2par.sv
// Serial MPEG-TS to byte-parallel converter: hunts for the sync bit, assembles MSB-first bytes
// and flags bad sync bytes, mid-byte resyncs and short packets. Define TS_SER2PAR_STATS_EN for packet/error counters.
module ts_ser2par (
    input  logic        clk,
    input  logic        rst,
    input  logic        ts_ser_i_data,
    input  logic        ts_ser_i_sync,
    input  logic        ts_ser_i_valid,
    output logic [7:0]  ts_par_o_data,
    output logic        ts_par_o_sync,
    output logic        ts_par_o_valid,
    output logic        ts_err_o,
    output logic [15:0] ts_pkt_cnt,
    output logic [15:0] ts_err_cnt
);

    localparam logic [7:0] SYNC_BYTE = 8'h47;
    localparam logic [7:0] LAST_BYTE = 8'd187;

    typedef enum logic {
        HUNT,
        SHIFT
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic        sync_q, sync_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [7:0]  byte_full;
    logic        sync_err;
    logic        hdr_err;

    assign byte_full = {shreg_q[6:0], ts_ser_i_data};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        sync_d     = 1'b0;
        valid_d    = 1'b0;
        sync_err   = 1'b0;
        hdr_err    = 1'b0;

        if (ts_ser_i_valid) begin
            if (ts_ser_i_sync) begin
                // A sync inside a packet means either a torn byte or a short packet; both are one error.
                sync_err   = (state_q == SHIFT) && ((bit_cnt_q != '0) || (byte_cnt_q != '0));
                state_d    = SHIFT;
                shreg_d    = {7'b0, ts_ser_i_data};
                bit_cnt_d  = 3'd1;
                byte_cnt_d = '0;
            end else if (state_q == SHIFT) begin
                shreg_d   = byte_full;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    valid_d = 1'b1;
                    data_d  = byte_full;
                    sync_d  = (byte_cnt_q == '0);
                    hdr_err = (byte_cnt_q == '0) && (byte_full != SYNC_BYTE);
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d    = HUNT;
                        byte_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
        end

        err_d = sync_err | hdr_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            sync_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            sync_q     <= sync_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign ts_par_o_data  = data_q;
    assign ts_par_o_sync  = sync_q;
    assign ts_par_o_valid = valid_q;
    assign ts_err_o       = err_q;

`ifdef TS_SER2PAR_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] err_cnt_q;
    logic        pkt_fire;

    assign pkt_fire = valid_d && (byte_cnt_q == LAST_BYTE);

    // Counters update on the same edge as the strobe they count, so they are current alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (pkt_fire && (pkt_cnt_q != '1)) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if (err_d && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign ts_pkt_cnt = pkt_cnt_q;
    assign ts_err_cnt = err_cnt_q;
`else
    assign ts_pkt_cnt = '0;
    assign ts_err_cnt = '0;
`endif

endmodule

// File: doc/ts_ser2par.md
TS_SER2PAR -- requirements
Module: ts_ser2par

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  system and serial TS bit clock, all logic on rising edge; rst  input  1  asynchronous active-high reset.
REQ-002 ts_ser_i_data  input  1  serial TS bit, MSB of each byte first.
REQ-003 ts_ser_i_sync  input  1  high with the first bit of a packet (MSB of the 0x47 sync byte).
REQ-004 ts_ser_i_valid  input  1  qualifies data/sync; when low, the cycle is ignored.
REQ-005 ts_par_o_data  output  8  assembled byte.
REQ-006 ts_par_o_sync  output  1  high with the first byte of a packet.
REQ-007 ts_par_o_valid  output  1  one-cycle strobe per assembled byte.
REQ-008 ts_err_o  output  1  one-cycle error strobe.
REQ-009 ts_pkt_cnt  output  16  accepted packet count; ts_err_cnt  output  16  error count.

Function
REQ-010 States SHALL be HUNT and SHIFT; a valid bit in HUNT without sync SHALL be discarded.
REQ-011 A valid bit with sync high SHALL, in either state, enter SHIFT, load the bit as byte bit 7, and clear the bit counter to 1 and the byte counter to 0.
REQ-012 In SHIFT, each valid bit SHALL shift into the byte register MSB-first and increment a 3-bit bit counter.
REQ-013 When the 8th bit of a byte is sampled at edge N, ts_par_o_data SHALL hold the byte and ts_par_o_valid SHALL be 1 for exactly the cycle after edge N (latency 1 clk).
REQ-014 ts_par_o_sync SHALL be 1 together with ts_par_o_valid for byte 0 of a packet only, 0 otherwise.
REQ-015 Byte counter SHALL count 0..187; after byte 187 is emitted, the state SHALL return to HUNT.
REQ-016 Byte 0 not equal to 0x47 SHALL still be emitted, and SHALL pulse ts_err_o together with its valid strobe.
REQ-017 Sync arriving with the bit counter nonzero (mid-byte) SHALL drop the partial byte, restart per REQ-011, and pulse ts_err_o one cycle later.
REQ-018 Sync arriving at a byte boundary with byte counter 1..187 (short packet) SHALL restart per REQ-011 and pulse ts_err_o one cycle later; the partial packet is not counted.
REQ-019 Valid low SHALL freeze all state, counters and shift register; gaps of any length are allowed mid-byte.
REQ-020 ts_par_o_data SHALL hold its last value when ts_par_o_valid is 0.
REQ-021 Simultaneous error sources in one cycle SHALL produce a single ts_err_o pulse and a single count.

Reset
REQ-022 While rst is high, the state SHALL be HUNT, and bit counter, byte counter, shift register and all outputs SHALL be 0.
REQ-023 Reset asserted mid-packet SHALL discard the partial byte and packet with no valid or error output; after release, the next sync is required.

Configuration
REQ-024 Macro TS_SER2PAR_STATS_EN defined: ts_pkt_cnt SHALL increment on emission of byte 187; ts_err_cnt SHALL increment on each ts_err_o pulse; both 16-bit, saturating at 0xFFFF.
REQ-025 Macro TS_SER2PAR_STATS_EN undefined: ts_pkt_cnt and ts_err_cnt ports SHALL remain present and be tied to 0, with no counter logic; all other behaviour SHALL be identical.

Verification
REQ-026 188-byte packet, byte 0 = 0x47, bytes i = i[7:0], valid always high -> 188 strobes spaced 8 clks, sync only on 0x47, no errors, pkt_cnt = 1.
REQ-027 Same packet with valid low for 3 clks after every 5th bit -> identical byte sequence, with strobe spacing extended accordingly.
REQ-028 Sync re-asserted after 3 bits of byte 10 -> no byte 10 strobe, one ts_err_o pulse, new packet starts, err_cnt = 1.
REQ-029 Packet with byte 0 = 0x46 -> byte emitted with sync = 1, ts_err_o = 1 in the same cycle, remaining 187 bytes emitted.
REQ-030 Random bits without sync after reset -> no strobes; rst pulsed mid-packet -> outputs 0 immediately, no strobes until the next sync.
REQ-031 Two back-to-back packets with the macro defined -> pkt_cnt = 2; with the macro undefined -> both counters remain 0.
